// File: rtl/pio_irq_capture_pkg.sv
// Shared register map, INFO field layout and edge-enable type for pio_irq_capture.
package pio_irq_capture_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
  localparam logic [2:0] ADDR_DB_LEN   = 3'd6;
  localparam logic [2:0] ADDR_INFO     = 3'd7;

  localparam int unsigned INFO_WIDTH_LSB  = 0;
  localparam int unsigned INFO_WIDTH_BITS = 8;
  localparam int unsigned INFO_SYNC_LSB   = 8;
  localparam int unsigned INFO_SYNC_BITS  = 4;
  localparam int unsigned INFO_DB_BIT     = 16;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_en_t;

endpackage

// File: rtl/pio_irq_capture_filter.sv
// One input bit: synchroniser, optional debounce, prev flop and qualified edge outputs.
// Debounce counter is built only with PIO_IRQ_CAPTURE_DEBOUNCE_EN defined.
module pio_irq_capture_filter
  import pio_irq_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_i,
  input  edge_en_t            edge_en_i,
  input  logic [DB_WIDTH-1:0] db_len_i,
  output logic                filt_c_o,
  output logic                rise_c_o,
  output logic                fall_c_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   filt;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PIO_IRQ_CAPTURE_DEBOUNCE_EN
  logic                filt_q, filt_d;
  logic [DB_WIDTH-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has disagreed with filt for db_len+1 cycles.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_out != filt_q) begin
      if (cnt_q == db_len_i) filt_d = sync_out;
      else                   cnt_d  = cnt_q + DB_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;
`else
  logic [DB_WIDTH-1:0] unused_db_len;
  assign unused_db_len = db_len_i;
  assign filt          = sync_out;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) prev_q <= 1'b0;
    else          prev_q <= filt;
  end

  assign filt_c_o = filt;
  assign rise_c_o =  filt & ~prev_q & edge_en_i.rise;
  assign fall_c_o = ~filt &  prev_q & edge_en_i.fall;

endmodule

// File: rtl/pio_irq_capture.sv
// Avalon-MM input PIO with per-bit rise/fall edge capture, W1C clear and level IRQ.
// Optional per-bit debounce via PIO_IRQ_CAPTURE_DEBOUNCE_EN.
module pio_irq_capture
  import pio_irq_capture_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RISE_INIT   = '0,
  parameter logic [WIDTH-1:0] FALL_INIT   = '1,
  parameter int unsigned      DB_WIDTH    = 8,
  parameter logic [DB_WIDTH-1:0] DB_INIT  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic             wr;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] filt, rise, fall;
  logic [WIDTH-1:0] cap_clr;
  logic [DB_WIDTH-1:0] db_len;
  logic             db_present;
  logic [31:0]      info;

  assign wr = chipselect & ~write_n;

`ifdef PIO_IRQ_CAPTURE_DEBOUNCE_EN
  logic [DB_WIDTH-1:0] db_len_q, db_len_d;

  always_comb begin
    db_len_d = db_len_q;
    if (wr && address == ADDR_DB_LEN) db_len_d = writedata[DB_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) db_len_q <= DB_INIT;
    else          db_len_q <= db_len_d;
  end

  assign db_len     = db_len_q;
  assign db_present = 1'b1;
`else
  logic [DB_WIDTH-1:0] unused_db_init;
  assign unused_db_init = DB_INIT;
  assign db_len         = '0;
  assign db_present     = 1'b0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_irq_capture_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_WIDTH   (DB_WIDTH)
    ) u_filter (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_i     (in_port[i]),
      .edge_en_i('{rise: rise_en_q[i], fall: fall_en_q[i]}),
      .db_len_i (db_len),
      .filt_c_o (filt[i]),
      .rise_c_o (rise[i]),
      .fall_c_o (fall[i])
    );
  end

  always_comb begin
    info = '0;
    info[INFO_WIDTH_LSB +: INFO_WIDTH_BITS] = INFO_WIDTH_BITS'(WIDTH);
    info[INFO_SYNC_LSB +: INFO_SYNC_BITS]   = INFO_SYNC_BITS'(SYNC_STAGES);
    info[INFO_DB_BIT]                       = db_present;
  end

  // Register writes; a new edge sets its capture bit even if cleared in the same cycle.
  always_comb begin
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    cap_clr   = '0;
    if (wr) begin
      case (address)
        ADDR_IRQ_MASK: mask_d    = writedata[WIDTH-1:0];
        ADDR_CAPTURE:  cap_clr   = writedata[WIDTH-1:0];
        ADDR_RISE_EN:  rise_en_d = writedata[WIDTH-1:0];
        ADDR_FALL_EN:  fall_en_d = writedata[WIDTH-1:0];
        default: ;
      endcase
    end
    cap_d = (cap_q & ~cap_clr) | rise | fall;
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA:     rdata_d = 32'(filt);
      ADDR_IRQ_MASK: rdata_d = 32'(mask_q);
      ADDR_CAPTURE:  rdata_d = 32'(cap_q);
      ADDR_RISE_EN:  rdata_d = 32'(rise_en_q);
      ADDR_FALL_EN:  rdata_d = 32'(fall_en_q);
      ADDR_DB_LEN:   rdata_d = 32'(db_len);
      ADDR_INFO:     rdata_d = info;
      default:       rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q    <= '0;
      cap_q     <= '0;
      rise_en_q <= RISE_INIT;
      fall_en_q <= FALL_INIT;
      rdata_q   <= '0;
    end else begin
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      rdata_q   <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule
